seed_timer: RTL
===============

Name: seed_timer

Overview:
- Successor to the game's original counter block: one clk_50M domain, no second clock input.
- Contains a parametrised free-running seed counter, which the FSM freezes to draw a pseudo-random card value.
- Contains an internal prescaler that generates the tick. This replaces the external 2 kHz clock.
- Contains a programmable one-shot tick timer that generalises the fixed two-second delay. The game FSM uses it for all timed pauses.

Parameters:
- WIDTH, 12, seed counter width in bits.
- CLK_HZ, 50000000, clk_50M frequency.
- TICK_HZ, 2000, tick rate. DIV = CLK_HZ/TICK_HZ. CLK_HZ must be an exact multiple of TICK_HZ and DIV >= 2; elaboration fails otherwise.
- TIMER_W, 16, timer duration width in ticks.

Ports:
- clk_50M  in  1  system clock. All logic is on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Zero  in  1  synchronous clear of the seed counter.
- i_Freeze  in  1  holds the seed counter while high.
- i_Start  in  1  single-cycle timer start/restart strobe.
- i_Duration  in  TIMER_W  timer length in ticks. Sampled only on a cycle where i_Start is accepted.
- i_Abort  in  1  cancels a running timer.
- o_Count  out  WIDTH  seed counter value.
- o_Tick  out  1  one-cycle pulse, once per DIV cycles.
- o_Busy  out  1  high while the timer is in RUN.
- o_Done  out  1  one-cycle pulse at timer expiry.
- o_Remaining  out  TIMER_W  ticks left in the current run.

Behaviour:
- Reset (i_Reset=1 at an edge): o_Count=0, prescaler=0, o_Tick=0, state IDLE, o_Busy=0, o_Done=0, o_Remaining=0. Reset overrides every other input.

Seed counter, per edge, in priority order:
- i_Zero: clear to 0.
- else i_Freeze: hold the current value.
- else: +1 modulo 2^WIDTH (2^WIDTH-1 wraps to 0).

Prescaler:
- Counts 0..DIV-1 and wraps.
- o_Tick is registered high for the single cycle in which the prescaler equals DIV-1.
- An accepted i_Start reloads the prescaler to 0, so the first tick of a run is a full DIV cycles away.

Timer FSM states: IDLE, RUN, DONE.
- IDLE, i_Start with i_Duration>0: o_Remaining<=i_Duration, go to RUN.
- IDLE, i_Start with i_Duration==0: go straight to DONE. o_Done is high the following cycle.
- RUN, tick: o_Remaining decrements by 1. When the decrement reaches 0, go to DONE.
- RUN, i_Start: restart. Reload o_Remaining from i_Duration, reset the prescaler, stay in RUN. A restart with i_Duration==0 goes to DONE.
- RUN, i_Abort: go to IDLE, o_Remaining<=0, no o_Done pulse.
- i_Abort and i_Start in the same cycle: abort wins and the start is dropped.
- DONE: o_Done=1 for exactly one cycle, then IDLE. i_Start during DONE is accepted as a fresh start from IDLE semantics.
- o_Busy = (state==RUN). o_Done = (state==DONE). Both are registered.
- i_Abort in IDLE or DONE has no effect.

Timing:
- With a start of duration N>0 sampled at edge 0, o_Done is high in the cycle following edge N*DIV.
- o_Busy is high from the cycle after edge 0 through the cycle ending at edge N*DIV.
- The seed counter is independent of timer activity.

Test Plan (CLK_HZ=10, TICK_HZ=1 so DIV=10; WIDTH=4; TIMER_W=8):
- Reset, then 20 free cycles -> o_Count goes 0..15, 0..3 (wraps at 15). o_Tick is high on cycles 10 and 20 only.
- i_Freeze high for 5 cycles at o_Count=7 -> o_Count holds 7. Assert i_Zero together with i_Freeze -> o_Count=0 next cycle.
- Start with i_Duration=3 -> o_Busy high for 30 cycles, o_Remaining steps 3,2,1,0, single o_Done pulse at cycle 30, then IDLE.
- Start with i_Duration=5, abort at cycle 23 -> o_Busy drops next cycle, o_Remaining=0, no o_Done ever.
- Start with duration 4, restart with duration 2 at cycle 15 -> o_Done at cycle 35. Start with duration 0 -> o_Done the next cycle, o_Busy never high.
- Assert i_Reset mid-RUN (o_Remaining=2) -> all outputs 0 next cycle, no o_Done. i_Start and i_Abort in the same cycle from IDLE -> stays IDLE.

Source files
------------

// File: rtl/seed_timer.sv
// Seed counter, tick prescaler and programmable one-shot tick timer on clk_50M.
// Outputs are registered: o_Tick/o_Busy/o_Done/o_Remaining change one edge after their cause.
// No backpressure: every strobe is acted on in the cycle it is sampled.
module seed_timer #(
  parameter int WIDTH   = 12,
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 2000,
  parameter int TIMER_W = 16
) (
  input  logic               clk_50M,
  input  logic               i_Reset,
  input  logic               i_Zero,
  input  logic               i_Freeze,
  input  logic               i_Start,
  input  logic [TIMER_W-1:0] i_Duration,
  input  logic               i_Abort,
  output logic [WIDTH-1:0]   o_Count,
  output logic               o_Tick,
  output logic               o_Busy,
  output logic               o_Done,
  output logic [TIMER_W-1:0] o_Remaining
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  // The tick period must be a whole number of clocks and at least two clocks long.
  generate
    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
      $error("seed_timer: CLK_HZ must be an exact multiple of TICK_HZ with CLK_HZ/TICK_HZ >= 2");
    end
  endgenerate

  // One-hot so that o_Busy/o_Done are straight flop outputs.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   count_q;
  logic [PW-1:0]      pre_q, pre_d;
  logic               tick_q;
  logic               start_acc;

  // Abort always beats start, in every state.
  assign start_acc = i_Start & ~i_Abort;

  // Seed counter: clear beats freeze, otherwise free-run and wrap.
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      count_q <= '0;
    end else if (i_Zero) begin
      count_q <= '0;
    end else if (!i_Freeze) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  // Next prescaler phase; an accepted start re-aligns it so a run's first tick is a full period away.
  always_comb begin
    pre_d = pre_q + PW'(1);
    if (start_acc || pre_q == PRE_LAST) begin
      pre_d = '0;
    end
  end

  // Prescaler and tick flop; tick is high exactly while the prescaler sits at its last phase.
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= (pre_d == PRE_LAST);
    end
  end

  // Timer state register together with the remaining-ticks count.
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Timer next-state: starts from IDLE/DONE, restart/abort/tick handling in RUN.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_acc) begin
          rem_d   = i_Duration;
          state_d = (i_Duration == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (i_Abort) begin
          state_d = S_IDLE;
          rem_d   = '0;
        end else if (start_acc) begin
          rem_d   = i_Duration;
          state_d = (i_Duration == '0) ? S_DONE : S_RUN;
        end else if (tick_q) begin
          rem_d = rem_q - TIMER_W'(1);
          if (rem_q == TIMER_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Output decode straight from the state and data flops.
  always_comb begin
    o_Busy      = state_q[1];
    o_Done      = state_q[2];
    o_Remaining = rem_q;
    o_Count     = count_q;
    o_Tick      = tick_q;
  end

endmodule
